// File: rtl/audio_stream_dac.sv
// Stereo PCM streamer for the WM8731: frames are queued in a FIFO and shifted out
// MSB-first in left-justified format, timed by the codec-mastered BCLK/DACLRCK.
module audio_stream_dac #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int UFLOW_W    = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          INIT_DONE,
    input  logic                          S_VALID,
    output logic                          S_READY,
    input  logic [SAMPLE_W-1:0]           S_LDATA,
    input  logic [SAMPLE_W-1:0]           S_RDATA,
    input  logic                          MONO,
    input  logic                          MUTE,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT,
    output logic                          NEXT_SAMPLE,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic [UFLOW_W-1:0]            UFLOW_CNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = 2 * SAMPLE_W;
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ALIGN, LEFT, RIGHT} state_t;

    state_t              state;
    logic [FW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [FW-1:0]       head;
    logic [SAMPLE_W-1:0] hold_right;
    logic [SAMPLE_W-1:0] shifter;
    logic [2:0]          bclk_sync;
    logic [2:0]          lrck_sync;
    logic                bclk_fall;
    logic                lrck_rise;
    logic                lrck_fall;
    logic                fifo_empty;
    logic                frame_load;
    logic                push;
    logic                pop;

    // Bit [1] is the synchronised pin, bit [2] its previous value for edge detection.
    always_comb begin
        bclk_fall  = ~bclk_sync[1] &  bclk_sync[2];
        lrck_rise  =  lrck_sync[1] & ~lrck_sync[2];
        lrck_fall  = ~lrck_sync[1] &  lrck_sync[2];
        fifo_empty = (FIFO_LEVEL == '0);
        S_READY    = Reset && (FIFO_LEVEL < FULL_LEVEL);
        push       = S_VALID && S_READY;
        frame_load = INIT_DONE && lrck_rise && ((state == ALIGN) || (state == RIGHT));
        pop        = frame_load && !fifo_empty;
        head       = fifo_mem[rd_ptr];
    end

    assign AUD_DACDAT = shifter[SAMPLE_W-1];

    always_ff @(posedge Clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {S_LDATA, MONO ? S_LDATA : S_RDATA};
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            FIFO_LEVEL  <= '0;
            UFLOW_CNT   <= '0;
            NEXT_SAMPLE <= 1'b0;
            hold_right  <= '0;
            shifter     <= '0;
            bclk_sync   <= '0;
            lrck_sync   <= '0;
        end else begin
            bclk_sync   <= {bclk_sync[1:0], AUD_BCLK};
            lrck_sync   <= {lrck_sync[1:0], AUD_DACLRCK};
            NEXT_SAMPLE <= 1'b0;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
            else if (pop && !push)
                FIFO_LEVEL <= FIFO_LEVEL - 1'b1;

            if (!INIT_DONE) begin
                state   <= IDLE;
                shifter <= '0;
            end else begin
                // Channel loads below override the shift when both fall in the same cycle.
                if (bclk_fall)
                    shifter <= {shifter[SAMPLE_W-2:0], 1'b0};
                case (state)
                    IDLE: state <= ALIGN;
                    ALIGN, RIGHT: begin
                        if (lrck_rise) begin
                            if (!fifo_empty) begin
                                hold_right  <= head[SAMPLE_W-1:0];
                                shifter     <= MUTE ? '0 : head[FW-1:SAMPLE_W];
                                NEXT_SAMPLE <= 1'b1;
                            end else begin
                                hold_right <= '0;
                                shifter    <= '0;
                                if (UFLOW_CNT != '1)
                                    UFLOW_CNT <= UFLOW_CNT + 1'b1;
                            end
                            state <= LEFT;
                        end
                    end
                    LEFT: begin
                        if (lrck_fall) begin
                            shifter <= MUTE ? '0 : hold_right;
                            state   <= RIGHT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_stream_dac.sv
// Directed bench for audio_stream_dac with a behavioural codec that drives
// BCLK/DACLRCK and captures each slot's bits at BCLK rise.
`timescale 1ns/1ps
module tb_audio_stream_dac;

    logic        Clk;
    logic        Reset;
    logic        INIT_DONE;
    logic        S_VALID;
    logic        S_READY;
    logic [15:0] S_LDATA;
    logic [15:0] S_RDATA;
    logic        MONO;
    logic        MUTE;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic        NEXT_SAMPLE;
    logic [3:0]  FIFO_LEVEL;
    logic [7:0]  UFLOW_CNT;

    int errors = 0;
    int checks = 0;
    int ns_count = 0;
    int hi_count = 0;
    bit mon_en = 1'b0;
    int bclk_half = 80;
    int lrck_bits = 16;
    int slot_cnt = 0;
    logic [15:0] slot_words[$];

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        mono;
        logic        mute;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[5];

    audio_stream_dac #(.SAMPLE_W(16), .FIFO_DEPTH(8), .UFLOW_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .INIT_DONE(INIT_DONE),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_LDATA(S_LDATA), .S_RDATA(S_RDATA),
        .MONO(MONO), .MUTE(MUTE), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_DACDAT(AUD_DACDAT), .NEXT_SAMPLE(NEXT_SAMPLE),
        .FIFO_LEVEL(FIFO_LEVEL), .UFLOW_CNT(UFLOW_CNT)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Codec model: LRCK changes on BCLK fall, data is captured on BCLK rise.
    initial begin
        logic [15:0] word;
        int nb;
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = 1'b0;
        forever begin
            for (int ch = 1; ch >= 0; ch--) begin
                AUD_DACLRCK = (ch == 1);
                word = '0;
                nb = lrck_bits;
                for (int b = 0; b < nb; b++) begin
                    #(bclk_half);
                    AUD_BCLK = 1'b1;
                    if (b < 16)
                        word = {word[14:0], AUD_DACDAT};
                    #(bclk_half);
                    AUD_BCLK = 1'b0;
                end
                slot_words.push_back(word);
                slot_cnt++;
            end
        end
    end

    always @(negedge Clk) begin
        if (NEXT_SAMPLE)
            ns_count++;
        if (mon_en && AUD_DACDAT)
            hi_count++;
    end

    function automatic logic [15:0] getSlot(input int idx);
        if (idx < slot_words.size())
            return slot_words[idx];
        return 16'hDEAD;
    endfunction

    function automatic logic [15:0] fillL(input int k);
        return 16'(16'h1000 + k * 16'h0101);
    endfunction

    function automatic logic [15:0] fillR(input int k);
        return ~fillL(k);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input logic mono);
        int n = 0;
        S_VALID = 1'b1;
        S_LDATA = l;
        S_RDATA = r;
        MONO    = mono;
        while (!S_READY && n < 200) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        S_VALID = 1'b0;
        checks++;
        if (n >= 200) begin
            errors++;
            $display("[TB] FAIL push_accept: S_READY stayed low for %0d cycles, required high", n);
        end
    endtask

    task automatic waitNs(input int target, input int budget, input string name);
        int n = 0;
        while (ns_count < target && n < budget) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (ns_count < target) begin
            errors++;
            $display("[TB] FAIL %s: NEXT_SAMPLE count %0d, required %0d", name, ns_count, target);
        end
    endtask

    task automatic waitSlots(input int target, input int budget, input string name);
        int n = 0;
        while (slot_cnt < target && n < budget) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (slot_cnt < target) begin
            errors++;
            $display("[TB] FAIL %s: slot count %0d, required %0d", name, slot_cnt, target);
        end
    endtask

    task automatic waitLevelZero(input int budget, input string name);
        int n = 0;
        while (FIFO_LEVEL != 0 && n < budget) begin
            @(negedge Clk);
            n++;
        end
        checkOutput(name, 32'(FIFO_LEVEL), 32'd0);
    endtask

    initial begin
        int ns0;
        int base;
        int n;

        vecs[0] = '{l: 16'hA5C3, r: 16'h0F0F, mono: 1'b0, mute: 1'b0, exp_l: 16'hA5C3, exp_r: 16'h0F0F};
        vecs[1] = '{l: 16'h8001, r: 16'h1234, mono: 1'b1, mute: 1'b0, exp_l: 16'h8001, exp_r: 16'h8001};
        vecs[2] = '{l: 16'h8001, r: 16'h1234, mono: 1'b1, mute: 1'b1, exp_l: 16'h0000, exp_r: 16'h0000};
        vecs[3] = '{l: 16'h7FFF, r: 16'h8000, mono: 1'b0, mute: 1'b0, exp_l: 16'h7FFF, exp_r: 16'h8000};
        vecs[4] = '{l: 16'h1234, r: 16'hFEDC, mono: 1'b0, mute: 1'b1, exp_l: 16'h0000, exp_r: 16'h0000};

        Reset = 1'b0; INIT_DONE = 1'b0; S_VALID = 1'b1;
        S_LDATA = 16'h5555; S_RDATA = 16'hAAAA; MONO = 1'b0; MUTE = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("reset_ready", 32'(S_READY), 32'd0);
        checkOutput("reset_dacdat", 32'(AUD_DACDAT), 32'd0);
        checkOutput("reset_level", 32'(FIFO_LEVEL), 32'd0);
        checkOutput("reset_uflow", 32'(UFLOW_CNT), 32'd0);
        checkOutput("reset_next", 32'(NEXT_SAMPLE), 32'd0);
        Reset = 1'b1; S_VALID = 1'b0;
        @(negedge Clk);
        checkOutput("release_ready", 32'(S_READY), 32'd1);

        // Fill the FIFO while the codec link is down, then hold a ninth frame.
        for (int k = 0; k < 8; k++)
            applyStimulus(fillL(k), fillR(k), 1'b0);
        checkOutput("full_level", 32'(FIFO_LEVEL), 32'd8);
        checkOutput("full_ready", 32'(S_READY), 32'd0);
        S_VALID = 1'b1; S_LDATA = fillL(8); S_RDATA = fillR(8); MONO = 1'b0;
        ns0 = ns_count;
        INIT_DONE = 1'b1;
        n = 0;
        while (!S_READY && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        checkOutput("ninth_ready", 32'(S_READY), 32'd1);
        base = slot_cnt;
        @(negedge Clk);
        S_VALID = 1'b0;
        checkOutput("ninth_one_pop", 32'(ns_count), 32'(ns0 + 1));
        checkOutput("ninth_level", 32'(FIFO_LEVEL), 32'd8);
        waitSlots(base + 18, 7000, "drain_slots");
        checkOutput("f0_left", 32'(getSlot(base)), 32'(fillL(0)));
        checkOutput("f0_right", 32'(getSlot(base + 1)), 32'(fillR(0)));
        checkOutput("f7_left", 32'(getSlot(base + 14)), 32'(fillL(7)));
        checkOutput("f7_right", 32'(getSlot(base + 15)), 32'(fillR(7)));
        checkOutput("f8_left", 32'(getSlot(base + 16)), 32'(fillL(8)));
        checkOutput("f8_right", 32'(getSlot(base + 17)), 32'(fillR(8)));
        checkOutput("drain_pulses", 32'(ns_count), 32'(ns0 + 9));
        checkOutput("drain_level", 32'(FIFO_LEVEL), 32'd0);

        for (int i = 0; i < 5; i++) begin
            MUTE = vecs[i].mute;
            ns0 = ns_count;
            applyStimulus(vecs[i].l, vecs[i].r, vecs[i].mono);
            checkOutput($sformatf("vec%0d_level_push", i), 32'(FIFO_LEVEL), 32'd1);
            waitNs(ns0 + 1, 1500, $sformatf("vec%0d_pop", i));
            base = slot_cnt;
            repeat (3) @(negedge Clk);
            checkOutput($sformatf("vec%0d_level_pop", i), 32'(FIFO_LEVEL), 32'd0);
            waitSlots(base + 2, 1500, $sformatf("vec%0d_slots", i));
            checkOutput($sformatf("vec%0d_left", i), 32'(getSlot(base)), 32'(vecs[i].exp_l));
            checkOutput($sformatf("vec%0d_right", i), 32'(getSlot(base + 1)), 32'(vecs[i].exp_r));
            checkOutput($sformatf("vec%0d_pulses", i), 32'(ns_count), 32'(ns0 + 1));
        end
        MUTE = 1'b0;

        // Drop INIT_DONE mid left slot with three frames still queued.
        ns0 = ns_count;
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
        applyStimulus(16'hC3A5, 16'h5A3C, 1'b0);
        applyStimulus(16'h0001, 16'h8000, 1'b0);
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        waitNs(ns0 + 1, 1500, "drop_first_pop");
        repeat (60) @(negedge Clk);
        checkOutput("drop_pre_dacdat", 32'(AUD_DACDAT), 32'd1);
        checkOutput("drop_pre_level", 32'(FIFO_LEVEL), 32'd3);
        INIT_DONE = 1'b0;
        @(negedge Clk);
        checkOutput("drop_dacdat", 32'(AUD_DACDAT), 32'd0);
        repeat (600) @(negedge Clk);
        checkOutput("drop_level_held", 32'(FIFO_LEVEL), 32'd3);
        checkOutput("drop_no_pop", 32'(ns_count), 32'(ns0 + 1));
        INIT_DONE = 1'b1;
        waitNs(ns0 + 2, 1500, "resume_pop");
        base = slot_cnt;
        waitSlots(base + 2, 1500, "resume_slots");
        checkOutput("resume_left", 32'(getSlot(base)), 32'h0000C3A5);
        checkOutput("resume_right", 32'(getSlot(base + 1)), 32'h00005A3C);
        waitLevelZero(3000, "resume_drain_level");

        // Fast codec clocks with 4-bit slots: truncation, then a long underflow run.
        bclk_half = 40;
        lrck_bits = 4;
        base = slot_cnt;
        waitSlots(base + 4, 3000, "fast_settle");
        ns0 = ns_count;
        applyStimulus(16'hA5C3, 16'hF0F0, 1'b0);
        waitNs(ns0 + 1, 500, "trunc_pop");
        base = slot_cnt;
        waitSlots(base + 2, 500, "trunc_slots");
        checkOutput("trunc_left", 32'(getSlot(base)), 32'h0000000A);
        checkOutput("trunc_right", 32'(getSlot(base + 1)), 32'h0000000F);

        waitSlots(slot_cnt + 2, 500, "uflow_align");
        ns0 = ns_count;
        hi_count = 0;
        mon_en = 1'b1;
        base = slot_cnt;
        waitSlots(base + 600, 25000, "uflow_slots");
        mon_en = 1'b0;
        checkOutput("uflow_dacdat_low", 32'(hi_count), 32'd0);
        checkOutput("uflow_no_pulses", 32'(ns_count), 32'(ns0));
        checkOutput("uflow_saturated", 32'(UFLOW_CNT), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_stream_dac.md
Name: audio_stream_dac

Overview:
- Parametrised successor to the single-sample audio driver.
- Buffers stereo PCM frames from the NIOS-II or DMA producer in a FIFO, using a valid/ready handshake.
- Serialises frames MSB-first onto the WM8731 DAC data line in left-justified mode, timed by the codec-mastered AUD_BCLK and AUD_DACLRCK.
- Adds mono duplication, mute, FIFO level reporting and underflow accounting.

Parameters:
- SAMPLE_W, 16: bits per channel sample (8..32).
- FIFO_DEPTH, 8: frames buffered; power of 2, minimum 2.
- UFLOW_W, 8: width of the saturating underflow counter.

Ports:
- Clk  in  1  system clock; must be at least 8x AUD_BCLK.
- Reset  in  1  synchronous, active-low reset.
- INIT_DONE  in  1  codec I2C configuration complete.
- S_VALID  in  1  producer frame valid.
- S_READY  out  1  FIFO can accept a frame.
- S_LDATA  in  SAMPLE_W  left sample, two's complement.
- S_RDATA  in  SAMPLE_W  right sample; ignored when MONO=1.
- MONO  in  1  1 = S_LDATA is written to both channels.
- MUTE  in  1  1 = serialise zeros; frames are still consumed.
- AUD_BCLK  in  1  codec bit clock (asynchronous).
- AUD_DACLRCK  in  1  codec frame clock (asynchronous); high = left.
- AUD_DACDAT  out  1  serial DAC data.
- NEXT_SAMPLE  out  1  one-cycle pulse per frame popped.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  frames held.
- UFLOW_CNT  out  UFLOW_W  frames missed due to empty FIFO; saturates at all-ones.

Behaviour:
- Reset (Reset=0 at a Clk edge): FIFO emptied, S_READY=0, AUD_DACDAT=0, NEXT_SAMPLE=0, FIFO_LEVEL=0, UFLOW_CNT=0, state=IDLE. A mid-frame reset drops the frame in flight.
- Synchronisation: AUD_BCLK and AUD_DACLRCK each pass through a 2-FF synchroniser plus one edge-detect register. Edge pulses occur 3 Clk cycles after the pin transition.
- FIFO write:
  - S_READY = (FIFO_LEVEL < FIFO_DEPTH) while Reset=1.
  - A push occurs when S_VALID && S_READY at a Clk edge.
  - The stored word is {S_LDATA, MONO ? S_LDATA : S_RDATA}; MONO is sampled at push time.
  - When full, S_READY=0 and the producer holds its data.
- FIFO_LEVEL is registered and updates the cycle after a push or pop. Simultaneous push and pop leave it unchanged.
- State machine IDLE, ALIGN, LEFT, RIGHT:
  - IDLE: AUD_DACDAT=0. Go to ALIGN when INIT_DONE=1.
  - ALIGN: wait for a synced LRCK rising edge, then perform a frame load and go to LEFT.
  - LEFT: on a synced LRCK falling edge, load the right half of the held frame into the shifter and go to RIGHT.
  - RIGHT: on a synced LRCK rising edge, perform a frame load and go to LEFT.
  - Any state: INIT_DONE=0 returns to IDLE next cycle. The FIFO keeps its contents; AUD_DACDAT=0.
- Frame load:
  - FIFO non-empty: pop the head into the frame-hold register, pulse NEXT_SAMPLE for 1 cycle, and load the left half into the shifter.
  - FIFO empty: hold register := 0, no NEXT_SAMPLE, UFLOW_CNT += 1 (saturating).
  - A push and a frame load in the same cycle with FIFO empty: the load sees empty (underflow); the push completes.
- Shifter:
  - The MSB drives AUD_DACDAT from the load cycle onward; this meets the codec's first BCLK rising edge given the clock ratio.
  - On each synced BCLK falling edge the shifter shifts left with zero fill.
  - After SAMPLE_W bits, AUD_DACDAT=0 until the next LRCK edge.
  - LRCK period shorter than SAMPLE_W BCLKs: the word is truncated at the LRCK edge, and the new channel is loaded.
- MUTE is sampled at load time. When 1, the shifter is loaded with 0; the pop, NEXT_SAMPLE and underflow accounting are unchanged.
- All outputs are registered except S_READY.

Test Plan:
- Reset=0 for 3 cycles while S_VALID=1 -> S_READY=0, AUD_DACDAT=0, FIFO_LEVEL=0, UFLOW_CNT=0. Release -> S_READY=1 on the next cycle.
- INIT_DONE=1; push frames (L=16'hA5C3, R=16'h0F0F); BCLK=Clk/16, LRCK=BCLK/32 -> left slot bits 1010010111000011 and right slot bits 0000111100001111, sampled at BCLK rise. NEXT_SAMPLE pulses exactly once per LRCK rising edge.
- Push 9 frames back-to-back into FIFO_DEPTH=8 before INIT_DONE -> FIFO_LEVEL=8, S_READY=0 after the 8th. The 9th is held until the first pop, then accepted; FIFO_LEVEL stays 8.
- Empty FIFO for 300 LRCK frames with UFLOW_W=8 -> AUD_DACDAT constant 0, UFLOW_CNT=255 (saturated), no NEXT_SAMPLE pulses.
- MONO=1, push L=16'h8001, R=16'h1234 -> both slots serialise 1000000000000001. Then MUTE=1 -> both slots are zero, NEXT_SAMPLE still pulses, and FIFO_LEVEL decrements.
- Drop INIT_DONE in the middle of a left slot with 3 frames queued -> AUD_DACDAT=0 within 1 cycle, FIFO_LEVEL stays 3. Reassert -> output resumes in ALIGN at the next LRCK rising edge with the queued head frame.
